memory_port_arbiter: RTL and testbench
======================================

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MEM_LAT, default 1, cycles from mem_en to valid mem_dout; legal range 1..4.
REQ-004 clk  in  1  single clock; every register updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ins_req  in  1  instruction-fetch request; held with ins_addr until the cycle in which ins_done is high.
REQ-007 ins_addr  in  ADDR_W  fetch physical address.
REQ-008 ins_dout  out  DATA_W  last fetched word.
REQ-009 ins_busy  out  1  equals ins_req & ~ins_done.
REQ-010 ins_done  out  1  one-cycle completion pulse for a fetch.
REQ-011 data_req, data_write  in  1 each  data request and write qualifier; held with data_addr and data_din until data_done.
REQ-012 data_addr  in  ADDR_W; data_din  in  DATA_W.
REQ-013 data_dout  out  DATA_W  last read word; data_busy  out  1  = data_req & ~data_done; data_done  out  1  completion pulse.
REQ-014 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W  shared single-port memory.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req, latch winner, addr, we (data_write for data, 0 for ins) and din; go to ISSUE; otherwise stay.
REQ-017 Arbitration: a single requester wins; on a tie the port not granted last wins (round-robin); last_grant updates on every grant.
REQ-018 ISSUE: mem_en=1 and mem_we=latched we for exactly one cycle, with mem_addr and mem_din from the latched values; load counter with MEM_LAT-1; go to WAIT.
REQ-019 WAIT: decrement the counter; when it is 0, capture mem_dout into the granted port's dout (read only; a write leaves dout unchanged) and go to RESP.
REQ-020 RESP: assert the granted port's done for one cycle; always go to IDLE, with no arbitration in RESP.
REQ-021 Latency: request seen in cycle 0 gives done in cycle MEM_LAT+2; one access per MEM_LAT+3 cycles at most.
REQ-022 mem_en and mem_we are 0 outside ISSUE; mem_addr and mem_din hold their latched values.
REQ-023 A requester that drops req mid-transaction does not abort it: the access completes and done still pulses.
REQ-024 Address and data pass through unmodified; there is no alignment check or translation.
REQ-025 dout registers hold their value until the next read completion on the same port.
REQ-026 The counter is 2 bits wide; MEM_LAT values outside 1..4 fail elaboration.

Reset
REQ-027 reset_n low, at any time including mid-transaction: state=IDLE, counter=0, last_grant=INS (data wins the first tie), ins_dout=0, data_dout=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-028 During reset, busy outputs follow req; any interrupted access is discarded with no done pulse.

Structure
REQ-029 Shared package memory_arbiter_pkg holds arb_state_t (IDLE/ISSUE/WAIT/RESP) and grant_t (GRANT_INS/GRANT_DATA).
REQ-030 The tie-break lives in one sub-module, memory_rr_select: inputs are the two reqs and last_grant; output is grant_t and a valid bit; it is purely combinational.

Verification (MEM_LAT=2 unless stated)
REQ-031 Fetch: ins_req=1, ins_addr=0x0040_0000, mem_dout=0x2408_0005 -> mem_en in cycle 1, ins_done in cycle 4, ins_dout=0x2408_0005, ins_busy 1 in cycles 0-3.
REQ-032 Tie after reset: ins_req and data_req both 1 in cycle 0 -> data granted first (done cycle 4), ins issued cycle 6, ins_done cycle 9.
REQ-033 Sustained contention for 4 accesses -> grants alternate D,I,D,I.
REQ-034 Write: data_write=1, addr=0x1000_0010, din=0xDEAD_BEEF -> mem_we=1 only in ISSUE, data_done cycle 4, data_dout unchanged.
REQ-035 reset_n low in WAIT -> next cycle IDLE, no done pulse; after release a pending ins_req issues normally.
REQ-036 MEM_LAT=4 single read -> done in cycle 6; MEM_LAT=1 -> done in cycle 3.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and grant identity.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_INS,
    GRANT_DATA
  } grant_t;

  // Latency counter width; it limits MEM_LAT to 1..4.
  localparam int CNT_W = 2;

endpackage

// File: rtl/memory_rr_select.sv
// Combinational two-way round-robin pick between fetch and data requests.
module memory_rr_select
  import memory_arbiter_pkg::*;
(
  input  logic   ins_req,
  input  logic   data_req,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    valid = ins_req | data_req;
    if (ins_req && data_req) begin
      grant = (last_grant == GRANT_INS) ? GRANT_DATA : GRANT_INS;
    end else if (data_req) begin
      grant = GRANT_DATA;
    end else begin
      grant = GRANT_INS;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with a
// fixed MEM_LAT read latency; one access in flight at a time.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] ins_addr,
  output logic [DATA_W-1:0] ins_dout,
  output logic              ins_busy,
  output logic              ins_done,
  input  logic              data_req,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_din,
  output logic [DATA_W-1:0] data_dout,
  output logic              data_busy,
  output logic              data_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
    $error("memory_port_arbiter: MEM_LAT must be in 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state, next_state;
  grant_t            gnt_q, last_grant, sel_grant;
  logic              sel_valid;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  memory_rr_select u_rr_select (
    .ins_req   (ins_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .grant     (sel_grant),
    .valid     (sel_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    ins_done   = 1'b0;
    data_done  = 1'b0;
    case (state)
      IDLE:  if (sel_valid) next_state = ISSUE;
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = we_q;
        next_state = WAIT;
      end
      WAIT:  if (cnt_q == '0) next_state = RESP;
      RESP: begin
        ins_done   = (gnt_q == GRANT_INS);
        data_done  = (gnt_q == GRANT_DATA);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign ins_busy  = ins_req & ~ins_done;
  assign data_busy = data_req & ~data_done;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

  // Fetches carry no write data, so an instruction grant latches zero into din.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= GRANT_INS;
      last_grant <= GRANT_INS;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      ins_dout   <= '0;
      data_dout  <= '0;
    end else begin
      case (state)
        IDLE: if (sel_valid) begin
          gnt_q      <= sel_grant;
          last_grant <= sel_grant;
          if (sel_grant == GRANT_DATA) begin
            addr_q <= data_addr;
            we_q   <= data_write;
            din_q  <= data_din;
          end else begin
            addr_q <= ins_addr;
            we_q   <= 1'b0;
            din_q  <= '0;
          end
        end
        ISSUE: cnt_q <= CNT_LOAD;
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!we_q) begin
            if (gnt_q == GRANT_INS) ins_dout  <= mem_dout;
            else                    data_dout <= mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter at MEM_LAT 2, 1 and 4 against a
// transaction-level timing model of grants, completions and captured words.
module tb_memory_port_arbiter;

  localparam int N    = 3;
  localparam int NCYC = 700;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        ins_req   [N];
  logic [31:0] ins_addr  [N];
  logic [31:0] ins_dout  [N];
  logic        ins_busy  [N];
  logic        ins_done  [N];
  logic        data_req  [N];
  logic        data_write[N];
  logic [31:0] data_addr [N];
  logic [31:0] data_din  [N];
  logic [31:0] data_dout [N];
  logic        data_busy [N];
  logic        data_done [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_din   [N];
  logic [31:0] mem_dout  [N];
  logic [31:0] garbage   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    logic        pv[4];
    logic [31:0] pa[4];

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ins_req   (ins_req[g]),
      .ins_addr  (ins_addr[g]),
      .ins_dout  (ins_dout[g]),
      .ins_busy  (ins_busy[g]),
      .ins_done  (ins_done[g]),
      .data_req  (data_req[g]),
      .data_write(data_write[g]),
      .data_addr (data_addr[g]),
      .data_din  (data_din[g]),
      .data_dout (data_dout[g]),
      .data_busy (data_busy[g]),
      .data_done (data_done[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_din   (mem_din[g]),
      .mem_dout  (mem_dout[g])
    );

    // Read word is valid only in the cycle exactly LAT after the enable cycle.
    always @(posedge clk) begin
      pv[0] <= mem_en[g] & ~mem_we[g];
      pa[0] <= mem_addr[g];
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
    assign mem_dout[g] = pv[LAT-1] ? mem_word(pa[LAT-1]) : garbage[g];
  end

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
  endtask

  // Reference model state, one set per instance.
  bit          active  [N];
  int          t_grant [N];
  int          free_at [N];
  int          p_port  [N];  // 0 = fetch, 1 = data
  logic [31:0] p_addr  [N];
  logic [31:0] p_din   [N];
  bit          p_we    [N];
  int          last_g  [N];
  logic [31:0] e_ins_dout [N];
  logic [31:0] e_data_dout[N];
  logic [31:0] e_maddr [N];
  logic [31:0] e_mdin  [N];
  bit          pend_i  [N];
  bit          pend_d  [N];

  initial begin
    bit rst_now, en, we, done_now, done_i, done_d;
    int prob;
    string nm;
    for (int k = 0; k < N; k++) begin
      ins_req[k] = 0; data_req[k] = 0; data_write[k] = 0;
      ins_addr[k] = 0; data_addr[k] = 0; data_din[k] = 0; garbage[k] = 0;
      active[k] = 0; free_at[k] = 0; last_g[k] = 0; t_grant[k] = 0;
      p_port[k] = 0; p_addr[k] = 0; p_din[k] = 0; p_we[k] = 0;
      e_ins_dout[k] = 0; e_data_dout[k] = 0; e_maddr[k] = 0; e_mdin[k] = 0;
      pend_i[k] = 0; pend_d[k] = 0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc     = c;
      rst_now = (c < 3) || (c >= 300 && c < 302) || (c == 450) || (c == 523);
      reset_n = !rst_now;
      prob    = (c < 80) ? 100 : 40;  // early phase: sustained contention

      for (int k = 0; k < N; k++) begin
        garbage[k] = $urandom();

        // Requesters hold fields while requesting; a granted one may drop req.
        if (!pend_i[k]) begin
          ins_req[k]  = 0;
          ins_addr[k] = $urandom();
          if ($urandom_range(0, 99) < prob) begin
            ins_req[k] = 1;
            pend_i[k]  = 1;
          end
        end else if (active[k] && p_port[k] == 0 && c > t_grant[k] && ins_req[k] &&
                     $urandom_range(0, 9) == 0) begin
          ins_req[k] = 0;
        end
        if (!pend_d[k]) begin
          data_req[k]   = 0;
          data_addr[k]  = $urandom();
          data_din[k]   = $urandom();
          data_write[k] = $urandom_range(0, 2) == 0;
          if ($urandom_range(0, 99) < prob) begin
            data_req[k] = 1;
            pend_d[k]   = 1;
          end
        end else if (active[k] && p_port[k] == 1 && c > t_grant[k] && data_req[k] &&
                     $urandom_range(0, 9) == 0) begin
          data_req[k] = 0;
        end

        // Model: reset discards everything; otherwise grant when the arbiter is free.
        if (rst_now) begin
          active[k] = 0; free_at[k] = 0; last_g[k] = 0;
          e_ins_dout[k] = 0; e_data_dout[k] = 0; e_maddr[k] = 0; e_mdin[k] = 0;
          if (!ins_req[k])  pend_i[k] = 0;
          if (!data_req[k]) pend_d[k] = 0;
        end else if (!active[k] && c >= free_at[k] && (ins_req[k] || data_req[k])) begin
          if (ins_req[k] && data_req[k]) p_port[k] = (last_g[k] == 0) ? 1 : 0;
          else                           p_port[k] = data_req[k] ? 1 : 0;
          last_g[k]  = p_port[k];
          active[k]  = 1;
          t_grant[k] = c;
          if (p_port[k] == 1) begin
            p_addr[k] = data_addr[k]; p_we[k] = data_write[k]; p_din[k] = data_din[k];
          end else begin
            p_addr[k] = ins_addr[k];  p_we[k] = 0;             p_din[k] = 0;
          end
        end
      end

      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        nm       = $sformatf("lat%0d", lat_of(k));
        en       = active[k] && (c == t_grant[k] + 1);
        we       = en && p_we[k];
        done_now = active[k] && (c == t_grant[k] + lat_of(k) + 2);
        done_i   = done_now && p_port[k] == 0;
        done_d   = done_now && p_port[k] == 1;
        if (en) begin
          e_maddr[k] = p_addr[k];
          e_mdin[k]  = p_din[k];
        end
        if (done_now && !p_we[k]) begin
          if (p_port[k] == 0) e_ins_dout[k]  = mem_word(p_addr[k]);
          else                e_data_dout[k] = mem_word(p_addr[k]);
        end

        check({nm, ".mem_en"},    32'(mem_en[k]),    32'(en));
        check({nm, ".mem_we"},    32'(mem_we[k]),    32'(we));
        check({nm, ".mem_addr"},  mem_addr[k],       e_maddr[k]);
        check({nm, ".mem_din"},   mem_din[k],        e_mdin[k]);
        check({nm, ".ins_done"},  32'(ins_done[k]),  32'(done_i));
        check({nm, ".data_done"}, 32'(data_done[k]), 32'(done_d));
        check({nm, ".ins_busy"},  32'(ins_busy[k]),  32'(ins_req[k] & ~done_i));
        check({nm, ".data_busy"}, 32'(data_busy[k]), 32'(data_req[k] & ~done_d));
        check({nm, ".ins_dout"},  ins_dout[k],       e_ins_dout[k]);
        check({nm, ".data_dout"}, data_dout[k],      e_data_dout[k]);

        if (done_now) begin
          active[k]  = 0;
          free_at[k] = c + 1;
          if (p_port[k] == 0) pend_i[k] = 0;
          else                pend_d[k] = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
